// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan sequencer placed directly upstream of a 4:1 select mux.
// For each enabled channel, in ascending order, it drives the mux select `s`,
// holds it for SETTLE_CYCLES cycles, then samples the mux output `y` on one
// more cycle. The sampled bits form a 4-bit snapshot, which is presented on
// `data` together with a one-cycle `done` pulse.
//
// Optional feature: define MUX_SCAN_CHANGE_EN to add the `changed` output.
// `changed` flags when a new snapshot differs from the previous `data`.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   start    scan request, sampled only in IDLE
//   mask     channel enables, latched when a start is accepted
//   y        output of the 4:1 mux
//   s        mux select
//   busy     scan in progress
//   done     one-cycle pulse, data updated in the same cycle
//   data     snapshot; bit n = sampled y for channel n (unmasked bits 0)
//   changed  (MUX_SCAN_CHANGE_EN only) snapshot differs from previous data
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       y,
    output logic [1:0] s,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
`ifdef MUX_SCAN_CHANGE_EN
    ,
    output logic       changed
`endif
);

    localparam int unsigned NCH = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned CW  = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NCH-1:0]  mask_q, mask_q_d;
    logic [NCH-1:0]  shadow, shadow_d;
    logic [NCH-1:0]  data_d;
    logic [SW-1:0]   s_d;
    logic            busy_d;
    logic            done_d;
`ifdef MUX_SCAN_CHANGE_EN
    logic            changed_d;
`endif

    logic [SW-1:0]   first_ch;
    logic [SW-1:0]   next_ch;
    logic            has_next;

    // Lowest enabled channel of the incoming mask (descending loop keeps the lowest).
    always_comb begin
        first_ch = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = SW'(i);
            end
        end
    end

    // Next enabled channel above the current select, from the latched mask.
    always_comb begin
        next_ch  = s;
        has_next = 1'b0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(s))) begin
                next_ch  = SW'(i);
                has_next = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        mask_q_d = mask_q;
        shadow_d = shadow;
        s_d      = s;
        busy_d   = busy;
        done_d   = 1'b0;
        data_d   = data;
`ifdef MUX_SCAN_CHANGE_EN
        changed_d = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    shadow_d = '0;
                    if (mask != '0) begin
                        mask_q_d = mask;
                        s_d      = first_ch;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = SETTLE;
                    end else begin
                        // Empty mask: report an all-zero snapshot without going busy.
                        state_d = DONE;
                    end
                end
            end

            SETTLE: begin
                cnt_d = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                shadow_d[s] = y;
                if (has_next) begin
                    s_d     = next_ch;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // done and data are registered together so both change on one edge.
                done_d  = 1'b1;
                data_d  = shadow;
`ifdef MUX_SCAN_CHANGE_EN
                changed_d = (shadow != data);
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mask_q <= '0;
            shadow <= '0;
            s      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            data   <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            mask_q <= mask_q_d;
            shadow <= shadow_d;
            s      <= s_d;
            busy   <= busy_d;
            done   <= done_d;
            data   <= data_d;
        end
    end

`ifdef MUX_SCAN_CHANGE_EN
    // Snapshot-changed flag, aligned with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            changed <= 1'b0;
        end else begin
            changed <= changed_d;
        end
    end
`endif

endmodule
